// File: rtl/mmio_initiator.sv
// CPU load/store to single-cycle peripheral register port bridge.
// Sub-doubleword stores use read-modify-write; loads extract and extend a lane.
module mmio_initiator (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  input  logic        i_req_wen,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_req_ready,
  output logic        o_resp_valid,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_valid,
  output logic        o_wen,
  output logic [63:0] o_addr,
  output logic [63:0] o_wdata,
  input  logic [63:0] i_rdata
);

  localparam int unsigned DW = 64;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t          state, state_nx;
  logic            wen_q, uns_q;
  logic [1:0]      size_q;
  logic [2:0]      off_q;
  logic [DW-1:0]   wdata_q, addr_q;

  logic            ready_q, valid_q, pwen_q, resp_valid_q, resp_err_q;
  logic [DW-1:0]   pwdata_q, resp_rdata_q;

  logic            ready_nx, valid_nx, pwen_nx, resp_valid_nx, resp_err_nx, lat;
  logic [DW-1:0]   pwdata_nx, resp_rdata_nx;

  logic [2:0]      align_mask;
  logic            misaligned;
  logic [5:0]      sh;
  logic [DW-1:0]   lane_mask, lane_sh, merged, rd_sh, ext;

  assign sh = {off_q, 3'b000};

  // Lane helpers: alignment test for the incoming request, merge/extend for the latched one
  always_comb begin
    align_mask = 3'b000;
    case (i_req_size)
      2'd0: align_mask = 3'b000;
      2'd1: align_mask = 3'b001;
      2'd2: align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    misaligned = |(i_req_addr[2:0] & align_mask);

    lane_mask = '1;
    case (size_q)
      2'd0: lane_mask = DW'(64'h0000_0000_0000_00FF);
      2'd1: lane_mask = DW'(64'h0000_0000_0000_FFFF);
      2'd2: lane_mask = DW'(64'h0000_0000_FFFF_FFFF);
      default: lane_mask = '1;
    endcase
    lane_sh = lane_mask << sh;
    merged  = (i_rdata & ~lane_sh) | ((wdata_q << sh) & lane_sh);

    rd_sh = i_rdata >> sh;
    ext   = rd_sh;
    case (size_q)
      2'd0: ext = uns_q ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
      2'd1: ext = uns_q ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
      2'd2: ext = uns_q ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
      default: ext = rd_sh;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_nx      = state;
    lat           = 1'b0;
    valid_nx      = 1'b0;
    pwen_nx       = 1'b0;
    pwdata_nx     = '0;
    resp_valid_nx = 1'b0;
    resp_err_nx   = 1'b0;
    resp_rdata_nx = '0;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          lat = 1'b1;
          if (misaligned) begin
            state_nx      = RESP;
            resp_valid_nx = 1'b1;
            resp_err_nx   = 1'b1;
          end else if (i_req_wen && i_req_size == 2'd3) begin
            state_nx  = WR;
            valid_nx  = 1'b1;
            pwen_nx   = 1'b1;
            pwdata_nx = i_req_wdata;
          end else begin
            state_nx = RD;
            valid_nx = 1'b1;
          end
        end
      end
      RD: begin
        if (wen_q) begin
          state_nx  = WR;
          valid_nx  = 1'b1;
          pwen_nx   = 1'b1;
          pwdata_nx = merged;
        end else begin
          state_nx      = RESP;
          resp_valid_nx = 1'b1;
          resp_rdata_nx = ext;
        end
      end
      WR: begin
        state_nx      = RESP;
        resp_valid_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    ready_nx = (state_nx == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wen_q        <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'd0;
      off_q        <= 3'd0;
      wdata_q      <= '0;
      addr_q       <= '0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      pwen_q       <= 1'b0;
      pwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state        <= state_nx;
      ready_q      <= ready_nx;
      valid_q      <= valid_nx;
      pwen_q       <= pwen_nx;
      pwdata_q     <= pwdata_nx;
      resp_valid_q <= resp_valid_nx;
      resp_err_q   <= resp_err_nx;
      resp_rdata_q <= resp_rdata_nx;
      if (lat) begin
        wen_q   <= i_req_wen;
        uns_q   <= i_req_unsigned;
        size_q  <= i_req_size;
        off_q   <= i_req_addr[2:0];
        wdata_q <= i_req_wdata;
        addr_q  <= {i_req_addr[63:3], 3'b000};
      end
    end
  end

  assign o_req_ready  = ready_q;
  assign o_valid      = valid_q;
  assign o_wen        = pwen_q;
  assign o_wdata      = pwdata_q;
  assign o_addr       = addr_q;
  assign o_resp_valid = resp_valid_q;
  assign o_resp_err   = resp_err_q;
  assign o_resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mmio_initiator.sv
// Directed bench for mmio_initiator: loads, RMW stores, misalignment, reset mid-access.
module tb_mmio_initiator;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_wen, i_req_unsigned;
  logic [63:0] i_req_addr, i_req_wdata, i_rdata;
  logic [1:0]  i_req_size;
  logic        o_req_ready, o_resp_valid, o_resp_err, o_valid, o_wen;
  logic [63:0] o_resp_rdata, o_addr, o_wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmio_initiator dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_wen(i_req_wen), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .o_req_ready(o_req_ready), .o_resp_valid(o_resp_valid), .o_resp_rdata(o_resp_rdata),
    .o_resp_err(o_resp_err), .o_valid(o_valid), .o_wen(o_wen), .o_addr(o_addr),
    .o_wdata(o_wdata), .i_rdata(i_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                     input logic uns, input logic [63:0] wdata);
    i_req_valid = 1'b1; i_req_wen = wen; i_req_addr = addr;
    i_req_size = size; i_req_unsigned = uns; i_req_wdata = wdata;
  endtask

  task automatic drop();
    i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = '0;
    i_req_size = 2'd0; i_req_unsigned = 1'b0; i_req_wdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    i_rdata = '0;
    req(1'b0, 64'h0200_4000, 2'd3, 1'b0, '0);  // presented during reset, must be ignored
    #1;
    chk("rst_ready", 64'(o_req_ready), 64'd1);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_addr", o_addr, 64'd0);
    chk("rst_resp_valid", 64'(o_resp_valid), 64'd0);
    step(); step();
    chk("rst_no_accept", 64'(o_valid), 64'd0);
    drop();
    rst = 1'b0;
    step();

    // Dword load
    i_rdata = 64'h0000_0000_0000_1234;
    req(1'b0, 64'h0200_BFF8, 2'd3, 1'b0, '0);
    step(); drop();
    chk("ld64_valid", 64'(o_valid), 64'd1);
    chk("ld64_wen", 64'(o_wen), 64'd0);
    chk("ld64_addr", o_addr, 64'h0200_BFF8);
    chk("ld64_ready", 64'(o_req_ready), 64'd0);
    chk("ld64_early_resp", 64'(o_resp_valid), 64'd0);
    step();
    chk("ld64_resp", 64'(o_resp_valid), 64'd1);
    chk("ld64_rdata", o_resp_rdata, 64'h1234);
    chk("ld64_err", 64'(o_resp_err), 64'd0);
    chk("ld64_valid_off", 64'(o_valid), 64'd0);
    step();
    chk("ld64_ready_back", 64'(o_req_ready), 64'd1);
    chk("ld64_pulse", 64'(o_resp_valid), 64'd0);

    // Signed byte load
    i_rdata = 64'h0000_0000_0000_8000;
    req(1'b0, 64'h0200_4001, 2'd0, 1'b0, '0);
    step(); drop();
    chk("lb_addr", o_addr, 64'h0200_4000);
    chk("lb_valid", 64'(o_valid), 64'd1);
    step();
    chk("lb_resp", 64'(o_resp_valid), 64'd1);
    chk("lb_rdata", o_resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    step();

    // Unsigned byte load
    req(1'b0, 64'h0200_4001, 2'd0, 1'b1, '0);
    step(); drop();
    chk("lbu_addr", o_addr, 64'h0200_4000);
    step();
    chk("lbu_rdata", o_resp_rdata, 64'h0000_0000_0000_0080);
    step();

    // Word store via read-modify-write
    i_rdata = 64'h1111_1111_2222_2222;
    req(1'b1, 64'h0200_4004, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF);
    step(); drop();
    chk("sw_rd_valid", 64'(o_valid), 64'd1);
    chk("sw_rd_wen", 64'(o_wen), 64'd0);
    chk("sw_rd_wdata", o_wdata, 64'd0);
    step();
    chk("sw_wr_valid", 64'(o_valid), 64'd1);
    chk("sw_wr_wen", 64'(o_wen), 64'd1);
    chk("sw_wr_wdata", o_wdata, 64'hDEAD_BEEF_2222_2222);
    chk("sw_wr_noresp", 64'(o_resp_valid), 64'd0);
    step();
    chk("sw_resp", 64'(o_resp_valid), 64'd1);
    chk("sw_rdata", o_resp_rdata, 64'd0);
    chk("sw_err", 64'(o_resp_err), 64'd0);
    chk("sw_wen_off", 64'(o_wen), 64'd0);
    step();

    // Dword store: no read phase
    i_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    req(1'b1, 64'h0200_4000, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF);
    step(); drop();
    chk("sd_valid", 64'(o_valid), 64'd1);
    chk("sd_wen", 64'(o_wen), 64'd1);
    chk("sd_wdata", o_wdata, 64'h0123_4567_89AB_CDEF);
    step();
    chk("sd_resp", 64'(o_resp_valid), 64'd1);
    chk("sd_valid_off", 64'(o_valid), 64'd0);
    step();

    // Misaligned half load, then back-to-back accept
    req(1'b0, 64'h0200_4003, 2'd1, 1'b0, '0);
    step(); drop();
    chk("mis_resp", 64'(o_resp_valid), 64'd1);
    chk("mis_err", 64'(o_resp_err), 64'd1);
    chk("mis_rdata", o_resp_rdata, 64'd0);
    chk("mis_valid", 64'(o_valid), 64'd0);
    step();
    chk("mis_ready", 64'(o_req_ready), 64'd1);
    chk("mis_err_pulse", 64'(o_resp_err), 64'd0);
    i_rdata = 64'h0000_0000_0000_0777;
    req(1'b0, 64'h0200_4008, 2'd3, 1'b0, '0);
    step(); drop();
    chk("mis_next_valid", 64'(o_valid), 64'd1);
    chk("mis_next_addr", o_addr, 64'h0200_4008);
    step();
    chk("mis_next_rdata", o_resp_rdata, 64'h777);
    step();

    // Byte store aborted by reset during its write cycle
    i_rdata = 64'd0;
    req(1'b1, 64'h0200_4002, 2'd0, 1'b0, 64'h0000_0000_0000_00AB);
    step(); drop();
    step();
    chk("rmw_wr_valid", 64'(o_valid), 64'd1);
    chk("rmw_wr_wdata", o_wdata, 64'h0000_0000_00AB_0000);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_wen", 64'(o_wen), 64'd0);
    chk("arst_ready", 64'(o_req_ready), 64'd1);
    step();
    chk("arst_noresp0", 64'(o_resp_valid), 64'd0);
    rst = 1'b0;
    step();
    chk("arst_noresp1", 64'(o_resp_valid), 64'd0);
    chk("arst_ready_after", 64'(o_req_ready), 64'd1);
    i_rdata = 64'h0000_0000_0000_0055;
    req(1'b0, 64'h0200_4000, 2'd3, 1'b0, '0);
    step(); drop();
    chk("post_valid", 64'(o_valid), 64'd1);
    step();
    chk("post_resp", 64'(o_resp_valid), 64'd1);
    chk("post_rdata", o_resp_rdata, 64'h55);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mmio_initiator.md
# mmio_initiator

Bus initiator that turns CPU load/store requests into accesses on the single-cycle peripheral register port used by the core-local timer (valid / wen / addr / wdata in, combinational rdata out). It sits between the memory stage and the timer/CLINT-style peripherals. The peripheral port has no byte strobes, so the block performs read-modify-write for sub-doubleword stores and lane extraction with sign/zero extension for loads.

## Interface
- No parameters.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  CPU request present
- i_req_wen  in  1  1 = store, 0 = load
- i_req_addr  in  64  byte address
- i_req_wdata  in  64  store data, right-aligned (valid bytes in LSBs)
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 dword
- i_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- o_req_ready  out  1  request accepted this cycle when valid & ready
- o_resp_valid  out  1  one-cycle response pulse; CPU must consume it
- o_resp_rdata  out  64  extended load data; 0 for stores and errors
- o_resp_err  out  1  misaligned access, qualified by o_resp_valid
- o_valid  out  1  peripheral access strobe
- o_wen  out  1  peripheral write enable
- o_addr  out  64  peripheral address, always 8-byte aligned
- o_wdata  out  64  peripheral write data
- i_rdata  in  64  peripheral read data, combinational from o_addr

## Operation
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, latch wen, size, unsigned and wdata; base = {addr[63:3],3'b0}; off = addr[2:0].
- Alignment check: off must be a multiple of 2^size bytes.
  - Misaligned request: go to RESP with err=1, rdata=0, no peripheral access.
- Aligned load: IDLE -> RD -> RESP.
- Aligned dword store: IDLE -> WR -> RESP.
- Aligned sub-dword store: IDLE -> RD -> WR -> RESP.
- RD:
  - o_valid=1, o_wen=0, o_addr=base, o_wdata=0.
  - i_rdata is registered into the old-data register at the end of the cycle.
- WR:
  - o_valid=1, o_wen=1, o_addr=base.
  - o_wdata = full wdata for dword stores.
  - Otherwise o_wdata = old data with bytes [off, off+2^size-1] replaced by the low 2^size bytes of wdata.
- RESP:
  - o_resp_valid=1; return to IDLE next cycle.
  - Load rdata = (old >> 8*off), truncated to 2^size bytes, sign- or zero-extended to 64.
  - A dword load returns old unchanged.
- o_valid is 0 in IDLE and RESP. o_addr holds the latched base in all states. o_wen and o_wdata are 0 outside WR.
- A read-modify-write of a free-running counter register loses the increments that occur between RD and WR. This is accepted behaviour: software writes counters with dword stores.

## Timing
- Let T be the accept cycle (i_req_valid & o_req_ready in IDLE).
- Response cycle by access type:
  - Load: RD at T+1, RESP at T+2.
  - Dword store: WR at T+1, RESP at T+2.
  - Sub-dword store: RD at T+1, WR at T+2, RESP at T+3.
  - Misaligned: RESP at T+1.
- o_req_ready is 0 from T+1 through RESP, so there is exactly one outstanding request. The next accept is possible the cycle after RESP.
- Exactly one o_valid cycle per read or write phase; no back-to-back peripheral cycles except RD->WR.
- Reset:
  - Immediately, without waiting for a clock edge, the FSM goes to IDLE and all latched registers clear.
  - Output values during and after reset: o_req_ready=1; o_resp_valid, o_resp_err, o_valid and o_wen = 0; o_addr, o_wdata and o_resp_rdata = 0.
  - Requests presented while rst=1 are not accepted.
- Reset mid-access: any in-flight RD or WR is abandoned, o_valid drops asynchronously, and no response is issued.

## Test plan
- Dword load, addr 0x0200_BFF8, size 11, i_rdata=0x0000_0000_0000_1234 -> o_valid=1 with o_wen=0 and o_addr=0x0200_BFF8 at T+1; o_resp_valid at T+2 with rdata 0x1234, err=0.
- Byte load, addr 0x0200_4001, i_rdata=0x0000_0000_0000_8000:
  - signed -> rdata 0xFFFF_FFFF_FFFF_FF80.
  - unsigned -> rdata 0x0000_0000_0000_0080.
  - In both cases o_addr=0x0200_4000.
- Word store, addr 0x0200_4004, wdata 0xDEAD_BEEF, old data 0x1111_1111_2222_2222 -> RD at T+1; WR at T+2 with o_wdata 0xDEAD_BEEF_2222_2222; response at T+3 with rdata 0.
- Dword store, addr 0x0200_4000, wdata 0x0123_4567_89AB_CDEF -> single o_valid cycle at T+1 with o_wen=1 and that o_wdata; no RD phase; response at T+2.
- Misaligned half load, addr 0x0200_4003 -> o_resp_valid and o_resp_err=1 at T+1; o_valid never asserted; next request accepted at T+2.
- rst pulsed during the WR cycle of a sub-dword store -> o_valid=0 immediately; no o_resp_valid; o_req_ready=1 after release; a following dword load completes normally in 2 cycles.
